// File: rtl/inout_bank_arbiter.sv
// Two-port arbiter for the banked InOut SRAM: decodes flat addresses, resolves same-bank
// collisions round-robin and returns read data one cycle later. Optional macro: ARB_STATS_EN.
module inout_bank_arbiter #(
  parameter int NUM_BANKS = 6,
  parameter int BANK_AW   = 15,
  parameter int DW        = 16,
  parameter int AW        = 18
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      a_valid_i,
  input  logic                      a_we_i,
  input  logic [AW-1:0]             a_addr_i,
  input  logic [DW-1:0]             a_wdata_i,
  output logic                      a_ready_o,
  output logic                      a_rvalid_o,
  output logic [DW-1:0]             a_rdata_o,
  output logic                      a_err_o,
  input  logic                      b_valid_i,
  input  logic                      b_we_i,
  input  logic [AW-1:0]             b_addr_i,
  input  logic [DW-1:0]             b_wdata_i,
  output logic                      b_ready_o,
  output logic                      b_rvalid_o,
  output logic [DW-1:0]             b_rdata_o,
  output logic                      b_err_o,
  output logic [NUM_BANKS-1:0]      sram_cs_o,
  output logic [NUM_BANKS-1:0]      sram_we_o,
  output logic [NUM_BANKS*BANK_AW-1:0] sram_addr_o,
  output logic [NUM_BANKS*DW-1:0]   sram_wdata_o,
  input  logic [NUM_BANKS*DW-1:0]   sram_rdata_i,
  output logic                      conflict_o
`ifdef ARB_STATS_EN
  ,
  input  logic                      stat_clr_i,
  output logic [31:0]               stat_conflict_cnt_o
`endif
);

  localparam int BSEL_W = AW - BANK_AW;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_t;

  ptr_t ptr_q, ptr_d;

  logic [BSEL_W-1:0] a_bank, b_bank;
  logic              a_in_range, b_in_range;
  logic              a_part, b_part;
  logic              a_oor, b_oor;
  logic              same_bank;
  logic              a_grant, b_grant;

  assign a_bank     = a_addr_i[AW-1:BANK_AW];
  assign b_bank     = b_addr_i[AW-1:BANK_AW];
  assign a_in_range = ({1'b0, a_bank} < (BSEL_W+1)'(NUM_BANKS));
  assign b_in_range = ({1'b0, b_bank} < (BSEL_W+1)'(NUM_BANKS));

  // Nothing is granted while reset is held, so the banks stay quiet during reset.
  assign a_part = rstn && a_valid_i && a_in_range;
  assign b_part = rstn && b_valid_i && b_in_range;
  assign a_oor  = rstn && a_valid_i && !a_in_range;
  assign b_oor  = rstn && b_valid_i && !b_in_range;

  assign same_bank = a_part && b_part && (a_bank == b_bank);
  assign a_grant   = a_part && (!same_bank || (ptr_q == PTR_A));
  assign b_grant   = b_part && (!same_bank || (ptr_q == PTR_B));

  assign a_ready_o  = a_grant || a_oor;
  assign b_ready_o  = b_grant || b_oor;
  assign conflict_o = same_bank;

  // The loser of a collision owns the next collision, so nobody loses twice in a row.
  always_comb begin
    ptr_d = ptr_q;
    if (same_bank) begin
      ptr_d = (ptr_q == PTR_A) ? PTR_B : PTR_A;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= PTR_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    sram_cs_o    = '0;
    sram_we_o    = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (a_grant && (a_bank == BSEL_W'(k))) begin
        sram_cs_o[k]                     = 1'b1;
        sram_we_o[k]                     = a_we_i;
        sram_addr_o[k*BANK_AW +: BANK_AW] = a_addr_i[BANK_AW-1:0];
        sram_wdata_o[k*DW +: DW]          = a_wdata_i;
      end else if (b_grant && (b_bank == BSEL_W'(k))) begin
        sram_cs_o[k]                     = 1'b1;
        sram_we_o[k]                     = b_we_i;
        sram_addr_o[k*BANK_AW +: BANK_AW] = b_addr_i[BANK_AW-1:0];
        sram_wdata_o[k*DW +: DW]          = b_wdata_i;
      end
    end
  end

  logic              a_rsp_rd_q, b_rsp_rd_q;
  logic              a_rsp_err_q, b_rsp_err_q;
  logic [BSEL_W-1:0] a_rsp_bank_q, b_rsp_bank_q;
  logic [DW-1:0]     a_rdata_q, b_rdata_q;
  logic [DW-1:0]     a_slice, b_slice;
  logic [DW-1:0]     a_rdata_now, b_rdata_now;

  // Out-of-range reads still answer with rvalid, but with zero data and err set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_rsp_rd_q   <= 1'b0;
      a_rsp_err_q  <= 1'b0;
      a_rsp_bank_q <= '0;
      b_rsp_rd_q   <= 1'b0;
      b_rsp_err_q  <= 1'b0;
      b_rsp_bank_q <= '0;
    end else begin
      a_rsp_rd_q  <= (a_grant || a_oor) && !a_we_i;
      a_rsp_err_q <= a_oor;
      b_rsp_rd_q  <= (b_grant || b_oor) && !b_we_i;
      b_rsp_err_q <= b_oor;
      if (a_grant) begin
        a_rsp_bank_q <= a_bank;
      end
      if (b_grant) begin
        b_rsp_bank_q <= b_bank;
      end
    end
  end

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (a_rsp_bank_q == BSEL_W'(k)) begin
        a_slice = sram_rdata_i[k*DW +: DW];
      end
      if (b_rsp_bank_q == BSEL_W'(k)) begin
        b_slice = sram_rdata_i[k*DW +: DW];
      end
    end
  end

  assign a_rdata_now = a_rsp_err_q ? '0 : a_slice;
  assign b_rdata_now = b_rsp_err_q ? '0 : b_slice;

  // The SRAM output is only meaningful in the response cycle, so keep a copy for holding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_rsp_rd_q) begin
        a_rdata_q <= a_rdata_now;
      end
      if (b_rsp_rd_q) begin
        b_rdata_q <= b_rdata_now;
      end
    end
  end

  assign a_rvalid_o = a_rsp_rd_q;
  assign b_rvalid_o = b_rsp_rd_q;
  assign a_err_o    = a_rsp_err_q;
  assign b_err_o    = b_rsp_err_q;
  assign a_rdata_o  = a_rsp_rd_q ? a_rdata_now : a_rdata_q;
  assign b_rdata_o  = b_rsp_rd_q ? b_rdata_now : b_rdata_q;

`ifdef ARB_STATS_EN
  logic [31:0] stat_cnt_q;

  // A clear wins over a coinciding conflict; the count saturates rather than wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_cnt_q <= '0;
    end else if (stat_clr_i) begin
      stat_cnt_q <= '0;
    end else if (conflict_o && (stat_cnt_q != 32'hFFFF_FFFF)) begin
      stat_cnt_q <= stat_cnt_q + 32'd1;
    end
  end

  assign stat_conflict_cnt_o = stat_cnt_q;
`endif

endmodule

// File: tb/tb_inout_bank_arbiter.sv
// Directed bench for inout_bank_arbiter with a small behavioural SRAM model on the bank side.
module tb_inout_bank_arbiter;

  localparam int NB  = 6;
  localparam int BAW = 15;
  localparam int DW  = 16;
  localparam int AW  = 18;

  logic clk = 1'b0;
  logic rstn;
  logic a_valid_i, a_we_i, b_valid_i, b_we_i;
  logic [AW-1:0] a_addr_i, b_addr_i;
  logic [DW-1:0] a_wdata_i, b_wdata_i;
  logic a_ready_o, a_rvalid_o, a_err_o, b_ready_o, b_rvalid_o, b_err_o;
  logic [DW-1:0] a_rdata_o, b_rdata_o;
  logic [NB-1:0] sram_cs_o, sram_we_o;
  logic [NB*BAW-1:0] sram_addr_o;
  logic [NB*DW-1:0] sram_wdata_o, sram_rdata_i;
  logic conflict_o;
`ifdef ARB_STATS_EN
  logic stat_clr_i;
  logic [31:0] stat_conflict_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] mem [int];

  inout_bank_arbiter dut (
    .clk(clk), .rstn(rstn),
    .a_valid_i(a_valid_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_ready_o(a_ready_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
    .b_valid_i(b_valid_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_ready_o(b_ready_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
    .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i), .conflict_o(conflict_o)
`ifdef ARB_STATS_EN
    , .stat_clr_i(stat_clr_i), .stat_conflict_cnt_o(stat_conflict_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Unwritten locations read back as {bank+1, offset[11:0]}.
  function automatic logic [15:0] pattern(input int k, input logic [14:0] off);
    return {4'(k + 1), off[11:0]};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (sram_cs_o[k]) begin
        if (sram_we_o[k]) begin
          mem[k*32768 + int'(sram_addr_o[k*BAW +: BAW])] = sram_wdata_o[k*DW +: DW];
        end else if (mem.exists(k*32768 + int'(sram_addr_o[k*BAW +: BAW]))) begin
          sram_rdata_i[k*DW +: DW] <= mem[k*32768 + int'(sram_addr_o[k*BAW +: BAW])];
        end else begin
          sram_rdata_i[k*DW +: DW] <= pattern(k, sram_addr_o[k*BAW +: BAW]);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic awe, input logic [AW-1:0] aa,
                               input logic [DW-1:0] ad, input logic bv, input logic bwe,
                               input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    @(negedge clk);
    a_valid_i = av; a_we_i = awe; a_addr_i = aa; a_wdata_i = ad;
    b_valid_i = bv; b_we_i = bwe; b_addr_i = ba; b_wdata_i = bd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    a_valid_i = 0; a_we_i = 0; a_addr_i = '0; a_wdata_i = '0;
    b_valid_i = 0; b_we_i = 0; b_addr_i = '0; b_wdata_i = '0;
`ifdef ARB_STATS_EN
    stat_clr_i = 1'b0;
`endif
    $display("[TB] start");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'($urandom), AW'($urandom), DW'($urandom),
                    1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
      checkOutput("rst_cs", 32'(sram_cs_o), 32'h0);
      checkOutput("rst_we", 32'(sram_we_o), 32'h0);
      checkOutput("rst_conflict", 32'(conflict_o), 32'h0);
      checkOutput("rst_a_ready", 32'(a_ready_o), 32'h0);
      tick();
      checkOutput("rst_a_rvalid", 32'(a_rvalid_o), 32'h0);
      checkOutput("rst_b_rvalid", 32'(b_rvalid_o), 32'h0);
      checkOutput("rst_a_err", 32'(a_err_o), 32'h0);
      checkOutput("rst_b_err", 32'(b_err_o), 32'h0);
      checkOutput("rst_a_rdata", 32'(a_rdata_o), 32'h0);
    end
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
    rstn = 1'b1;
    tick();

    // Parallel banks
    applyStimulus(1, 0, 18'h00010, '0, 1, 1, 18'h08005, 16'hBEEF);
    checkOutput("par_a_ready", 32'(a_ready_o), 32'h1);
    checkOutput("par_b_ready", 32'(b_ready_o), 32'h1);
    checkOutput("par_cs", 32'(sram_cs_o), 32'h03);
    checkOutput("par_we", 32'(sram_we_o), 32'h02);
    checkOutput("par_addr0", 32'(sram_addr_o[0*BAW +: BAW]), 32'h0010);
    checkOutput("par_addr1", 32'(sram_addr_o[1*BAW +: BAW]), 32'h0005);
    checkOutput("par_wdata1", 32'(sram_wdata_o[1*DW +: DW]), 32'hBEEF);
    checkOutput("par_conflict", 32'(conflict_o), 32'h0);
    tick();
    checkOutput("par_a_rvalid", 32'(a_rvalid_o), 32'h1);
    checkOutput("par_a_rdata", 32'(a_rdata_o), 32'h1010);
    checkOutput("par_b_rvalid", 32'(b_rvalid_o), 32'h0);

    // Collision on bank2: A, B, A
    applyStimulus(1, 0, 18'h10000, '0, 1, 0, 18'h10001, '0);
    checkOutput("col1_a_ready", 32'(a_ready_o), 32'h1);
    checkOutput("col1_b_ready", 32'(b_ready_o), 32'h0);
    checkOutput("col1_conflict", 32'(conflict_o), 32'h1);
    checkOutput("col1_cs", 32'(sram_cs_o), 32'h04);
    checkOutput("col1_addr2", 32'(sram_addr_o[2*BAW +: BAW]), 32'h0000);
    tick();
    checkOutput("col1_a_rvalid", 32'(a_rvalid_o), 32'h1);
    checkOutput("col1_a_rdata", 32'(a_rdata_o), 32'h3000);
    checkOutput("col1_b_rvalid", 32'(b_rvalid_o), 32'h0);
    applyStimulus(1, 0, 18'h10000, '0, 1, 0, 18'h10001, '0);
    checkOutput("col2_a_ready", 32'(a_ready_o), 32'h0);
    checkOutput("col2_b_ready", 32'(b_ready_o), 32'h1);
    checkOutput("col2_conflict", 32'(conflict_o), 32'h1);
    checkOutput("col2_addr2", 32'(sram_addr_o[2*BAW +: BAW]), 32'h0001);
    tick();
    checkOutput("col2_b_rvalid", 32'(b_rvalid_o), 32'h1);
    checkOutput("col2_b_rdata", 32'(b_rdata_o), 32'h3001);
    checkOutput("col2_a_rvalid", 32'(a_rvalid_o), 32'h0);
    checkOutput("col2_a_hold", 32'(a_rdata_o), 32'h3000);
    applyStimulus(1, 0, 18'h10000, '0, 1, 0, 18'h10001, '0);
    checkOutput("col3_a_ready", 32'(a_ready_o), 32'h1);
    checkOutput("col3_b_ready", 32'(b_ready_o), 32'h0);
    checkOutput("col3_conflict", 32'(conflict_o), 32'h1);
    tick();
    checkOutput("col3_a_rvalid", 32'(a_rvalid_o), 32'h1);

    // Pointer now at B; bank1 collision then read back the written word
    applyStimulus(1, 0, 18'h08005, '0, 1, 0, 18'h08000, '0);
    checkOutput("col4_a_ready", 32'(a_ready_o), 32'h0);
    checkOutput("col4_b_ready", 32'(b_ready_o), 32'h1);
    tick();
    checkOutput("col4_b_rdata", 32'(b_rdata_o), 32'h2000);
    applyStimulus(1, 0, 18'h08005, '0, 1, 0, 18'h08000, '0);
    checkOutput("col5_a_ready", 32'(a_ready_o), 32'h1);
    tick();
    checkOutput("wr_readback", 32'(a_rdata_o), 32'hBEEF);

    // Out of range
    applyStimulus(0, 0, '0, '0, 1, 0, 18'h30000, '0);
    checkOutput("oor_b_ready", 32'(b_ready_o), 32'h1);
    checkOutput("oor_cs", 32'(sram_cs_o), 32'h0);
    checkOutput("oor_conflict", 32'(conflict_o), 32'h0);
    tick();
    checkOutput("oor_b_err", 32'(b_err_o), 32'h1);
    checkOutput("oor_b_rvalid", 32'(b_rvalid_o), 32'h1);
    checkOutput("oor_b_rdata", 32'(b_rdata_o), 32'h0);
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
    tick();
    checkOutput("oor_b_err_clr", 32'(b_err_o), 32'h0);
    checkOutput("oor_b_rvalid_clr", 32'(b_rvalid_o), 32'h0);
    applyStimulus(1, 1, 18'h3FFFF, 16'h1234, 1, 0, 18'h2FFFF, '0);
    checkOutput("edge_a_ready", 32'(a_ready_o), 32'h1);
    checkOutput("edge_b_ready", 32'(b_ready_o), 32'h1);
    checkOutput("edge_cs", 32'(sram_cs_o), 32'h20);
    checkOutput("edge_we", 32'(sram_we_o), 32'h0);
    checkOutput("edge_addr5", 32'(sram_addr_o[5*BAW +: BAW]), 32'h7FFF);
    tick();
    checkOutput("edge_a_err", 32'(a_err_o), 32'h1);
    checkOutput("edge_a_rvalid", 32'(a_rvalid_o), 32'h0);
    checkOutput("edge_b_rvalid", 32'(b_rvalid_o), 32'h1);
    checkOutput("edge_b_rdata", 32'(b_rdata_o), 32'h6FFF);
    checkOutput("edge_b_err", 32'(b_err_o), 32'h0);

    // Streaming reads on port A
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, 0, AW'(i), '0, 0, 0, '0, '0);
      checkOutput("stream_ready", 32'(a_ready_o), 32'h1);
      tick();
      checkOutput("stream_rvalid", 32'(a_rvalid_o), 32'h1);
      checkOutput("stream_rdata", 32'(a_rdata_o), 32'(pattern(0, 15'(i))));
    end

    // Reset while a read is in flight
    applyStimulus(1, 0, 18'h00020, '0, 0, 0, '0, '0);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(a_ready_o), 32'h0);
    tick();
    checkOutput("midrst_rvalid", 32'(a_rvalid_o), 32'h0);
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
    rstn = 1'b1;
    tick();
    checkOutput("midrst_rvalid_after", 32'(a_rvalid_o), 32'h0);
    applyStimulus(1, 0, 18'h20000, '0, 1, 0, 18'h20001, '0);
    checkOutput("midrst_ptr_a", 32'(a_ready_o), 32'h1);
    checkOutput("midrst_ptr_b", 32'(b_ready_o), 32'h0);
    tick();

`ifdef ARB_STATS_EN
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    checkOutput("stat_clear", stat_conflict_cnt_o, 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 18'h18000, '0, 1, 0, 18'h18001, '0);
      tick();
    end
    checkOutput("stat_five", stat_conflict_cnt_o, 32'd5);
    applyStimulus(1, 0, 18'h18000, '0, 1, 0, 18'h18001, '0);
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    checkOutput("stat_clr_wins", stat_conflict_cnt_o, 32'd0);
`endif

    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inout_bank_arbiter.md
Name: inout_bank_arbiter

Overview:
Shares the 6-bank InOut SRAM (6 x 32768 words x 16 b, 384 KB) between two requester ports, A and B. A is the PE-array operand fetch; B is the output writeback / DMA path. The block decodes a flat word address into bank and offset, and drives per-bank chip-select, write-enable, address and data. Accesses to different banks proceed in parallel. A same-bank collision is resolved round-robin. Read data returns with fixed 1-cycle latency.

Parameters:
NUM_BANKS, 6, number of SRAM banks.
BANK_AW, 15, word-address bits per bank (32768 words).
DW, 16, data width.
AW, 18, flat word-address width; bank = addr[AW-1:BANK_AW], offset = addr[BANK_AW-1:0].

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
a_valid_i  in  1  port A request valid
a_we_i  in  1  port A write (1) / read (0)
a_addr_i  in  AW  port A flat word address
a_wdata_i  in  DW  port A write data
a_ready_o  out  1  port A request accepted this cycle
a_rvalid_o  out  1  port A read data valid
a_rdata_o  out  DW  port A read data
a_err_o  out  1  port A out-of-range response pulse
b_valid_i, b_we_i, b_addr_i, b_wdata_i, b_ready_o, b_rvalid_o, b_rdata_o, b_err_o: same as port A, for port B
sram_cs_o  out  NUM_BANKS  per-bank chip select, active high
sram_we_o  out  NUM_BANKS  per-bank write enable, active high
sram_addr_o  out  NUM_BANKS*BANK_AW  per-bank offset, bank k at slice [k*BANK_AW +: BANK_AW]
sram_wdata_o  out  NUM_BANKS*DW  per-bank write data
sram_rdata_i  in  NUM_BANKS*DW  per-bank read data, valid the cycle after cs
conflict_o  out  1  same-bank collision this cycle

Behaviour:
- Clocking and reset: single clock; reset is asynchronous, active-low (rstn). All registers clear on reset.
- Reset values: rvalid/err outputs 0; rdata outputs 0; round-robin pointer = A; response-pipeline bank indices 0.
- Handshake: a transfer occurs when valid_i && ready_o in the same cycle. ready_o is combinational from both valid_i signals and the pointer. The requester holds address/data/we stable until it is accepted.
- Bank decode: bank index >= NUM_BANKS (addr >= 196608) is out of range. Such a request is always ready, drives no cs, and is not an arbitration participant. Next cycle: err_o=1; if it was a read, rvalid_o=1 with rdata_o=0. Writes to out-of-range addresses are dropped.
- Arbitration, combinational per cycle:
  - Different in-range banks: both granted, both banks driven.
  - Same bank: the port named by the pointer is granted, the other gets ready_o=0, and conflict_o=1.
  - Only one valid: it is granted regardless of the pointer.
- Pointer update (registered): on a conflict cycle, the pointer moves to the losing port. Otherwise it is unchanged. Consequence: a port loses at most one consecutive collision.
- SRAM drive: for a granted in-range request, set cs[bank]=1, we[bank]=we_i, and drive addr/wdata slices. Non-selected banks: cs=0, we=0, addr/wdata=0.
- Read return: each port registers (read_granted, bank). The next cycle, rvalid_o=1 and rdata_o = sram_rdata_i slice of the registered bank. rdata_o holds its last value when rvalid_o=0.
- Writes: no response pulse (except err_o for out-of-range).
- Back-to-back: one accepted request per port per cycle; full throughput with no bubbles when the ports hit different banks.
- Same-address read/write from the two ports cannot occur in one cycle, since a bank serves one access per cycle. Ordering follows the grant order.
- Reset mid-operation: in-flight responses are discarded; no rvalid after reset release without a new grant.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: adds ports stat_clr_i (in, 1) and stat_conflict_cnt_o (out, 32). The counter increments on every conflict_o cycle, saturates at 0xFFFFFFFF, and is cleared synchronously by stat_clr_i. If stat_clr_i coincides with a conflict, the counter result is 0. The counter resets to 0.
- Undefined: no counter and no extra ports; arbitration behaviour is identical.

Test Plan:
- Reset/idle: hold rstn=0 with random inputs -> all cs/we=0, rvalid/err=0, conflict_o=0. After release, pointer=A.
- Parallel banks: A read 0x00010 (bank0), B write 0x08005=0xBEEF (bank1), same cycle -> both ready. cs=6'b000011, we[1]=1, addr slice1=0x0005. Next cycle a_rvalid_o=1 with bank0 data.
- Collision round-robin: A and B both read bank2 (0x10000, 0x10001) for 3 cycles -> grants A, B, A. conflict_o=1 each cycle. Each rvalid arrives 1 cycle after the corresponding grant.
- Out-of-range: B read 0x30000 -> b_ready_o=1, no cs. Next cycle b_err_o=1, b_rvalid_o=1, b_rdata_o=0.
- Streaming: A reads 0x00000..0x000FF consecutively, B idle -> 256 accepts in 256 cycles, data returned in order with 1-cycle latency.
- ARB_STATS_EN: 5 collision cycles, then stat_clr_i coinciding with a 6th collision -> count reads 5, then 0.
